// File: rtl/vram_text_writer.sv
// vram_text_writer
// Turns a stream of ASCII codes into character VRAM writes for an 80x30
// (default) text screen. A write lands at linear address row*COLS+col, which
// is the layout the pixel-side text renderer reads. Control codes move the
// cursor. The block also blanks lines and the whole screen itself.
//
// Ports
//   clk, rst           single rising-edge clock, async active-high reset
//   char_valid/_data   CPU-side offer of one ASCII code
//   char_ready         high when a code can be accepted (== !busy)
//   busy               a clear sweep is in progress
//   vram_we/waddr/wdata registered one-cycle VRAM write port
//   cursor_col/row     registered cursor position
//
// state      | meaning
// CLEAR_ALL  | blanking the whole screen, address = clr_cnt
// CLEAR_LINE | blanking the cursor row, address = row*COLS + clr_cnt
// IDLE       | accepting characters
module vram_text_writer #(
  parameter int         COLS  = 80,
  parameter int         ROWS  = 30,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  output logic        busy,
  output logic        vram_we,
  output logic [11:0] vram_waddr,
  output logic [7:0]  vram_wdata,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row
);

  typedef enum logic [1:0] {
    ST_CLEAR_ALL  = 2'd0,
    ST_CLEAR_LINE = 2'd1,
    ST_IDLE       = 2'd2
  } state_t;

  localparam logic [6:0]  COL_LAST      = 7'(COLS - 1);
  localparam logic [4:0]  ROW_LAST      = 5'(ROWS - 1);
  localparam logic [11:0] CLR_LINE_LAST = 12'(COLS - 1);
  localparam logic [11:0] CLR_ALL_LAST  = 12'(COLS * ROWS - 1);
  localparam logic [11:0] COLS_12       = 12'(COLS);

  state_t      state_q, state_d;
  logic [11:0] clr_cnt_q, clr_cnt_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic        we_q, we_d;
  logic [11:0] waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;

  logic [11:0] row_base;
  logic [4:0]  row_next;
  logic [6:0]  col_m1;
  logic        accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR_ALL;
      clr_cnt_q <= 12'd0;
      col_q     <= 7'd0;
      row_q     <= 5'd0;
      we_q      <= 1'b0;
      waddr_q   <= 12'd0;
      wdata_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      col_q     <= col_d;
      row_q     <= row_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    col_d     = col_q;
    row_d     = row_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;

    row_base = {7'd0, row_q} * COLS_12;
    row_next = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;
    col_m1   = col_q - 7'd1;
    accept   = char_valid && (state_q == ST_IDLE);

    case (state_q)
      ST_CLEAR_ALL: begin
        we_d      = 1'b1;
        waddr_d   = clr_cnt_q;
        wdata_d   = BLANK;
        clr_cnt_d = clr_cnt_q + 12'd1;
        if (clr_cnt_q == CLR_ALL_LAST) state_d = ST_IDLE;
      end

      ST_CLEAR_LINE: begin
        // row_q already holds the destination row of the advance
        we_d      = 1'b1;
        waddr_d   = row_base + clr_cnt_q;
        wdata_d   = BLANK;
        clr_cnt_d = clr_cnt_q + 12'd1;
        if (clr_cnt_q == CLR_LINE_LAST) state_d = ST_IDLE;
      end

      ST_IDLE: begin
        if (accept) begin
          case (char_data)
            8'h0A: begin
              col_d     = 7'd0;
              row_d     = row_next;
              clr_cnt_d = 12'd0;
              state_d   = ST_CLEAR_LINE;
            end
            8'h0D: col_d = 7'd0;
            8'h08: begin
              if (col_q != 7'd0) begin
                col_d   = col_m1;
                we_d    = 1'b1;
                waddr_d = row_base + {5'd0, col_m1};
                wdata_d = BLANK;
              end
            end
            8'h0C: begin
              col_d     = 7'd0;
              row_d     = 5'd0;
              clr_cnt_d = 12'd0;
              state_d   = ST_CLEAR_ALL;
            end
            default: begin
              we_d    = 1'b1;
              waddr_d = row_base + {5'd0, col_q};
              wdata_d = char_data;
              if (col_q == COL_LAST) begin
                col_d     = 7'd0;
                row_d     = row_next;
                clr_cnt_d = 12'd0;
                state_d   = ST_CLEAR_LINE;
              end else begin
                col_d = col_q + 7'd1;
              end
            end
          endcase
        end
      end

      // unused encoding: recover by redrawing a blank screen
      default: begin
        clr_cnt_d = 12'd0;
        state_d   = ST_CLEAR_ALL;
      end
    endcase
  end

  assign busy       = (state_q != ST_IDLE);
  assign char_ready = !busy;
  assign vram_we    = we_q;
  assign vram_waddr = waddr_q;
  assign vram_wdata = wdata_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule

// File: tb/tb_vram_text_writer.sv
// Directed bench for vram_text_writer at default parameters (80x30, blank 0x20).
// Inputs are driven and outputs sampled on the falling edge, so every sample
// shows the result of the preceding rising edge.
module tb_vram_text_writer;

  logic        clk;
  logic        rst;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        busy;
  logic        vram_we;
  logic [11:0] vram_waddr;
  logic [7:0]  vram_wdata;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;

  int n_cmp;
  int n_err;

  vram_text_writer dut (
    .clk        (clk),
    .rst        (rst),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .busy       (busy),
    .vram_we    (vram_we),
    .vram_waddr (vram_waddr),
    .vram_wdata (vram_wdata),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wr(input logic we, input logic [11:0] a, input logic [7:0] d);
    return {11'd0, we, a, d};
  endfunction

  function automatic logic [31:0] cur(input logic [4:0] r, input logic [6:0] c);
    return {20'd0, r, c};
  endfunction

  // present a code for one rising edge, return at the following falling edge
  task automatic send(input logic [7:0] c);
    char_valid = 1'b1;
    char_data  = c;
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  // full-screen sweep: 2400 consecutive writes, ready rises with the last one
  task automatic clear_all_check(input string tag);
    for (int i = 0; i < 2400; i++) begin
      @(negedge clk);
      check({tag, "_wr"}, wr(vram_we, vram_waddr, vram_wdata), wr(1'b1, 12'(i), 8'h20));
      if (i == 0 || i >= 2398) check({tag, "_rdy"}, 32'(char_ready), 32'(i == 2399));
    end
    @(negedge clk);
    check({tag, "_we_end"}, 32'(vram_we), 32'd0);
    check({tag, "_cur_end"}, cur(cursor_row, cursor_col), cur(5'd0, 7'd0));
  endtask

  // line sweep following an accept; caller is at the accept's falling edge
  task automatic clear_line_check(input string tag, input int base);
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      check({tag, "_wr"}, wr(vram_we, vram_waddr, vram_wdata), wr(1'b1, 12'(base + k), 8'h20));
      check({tag, "_rdy"}, 32'(char_ready), 32'(k == 79));
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b1;
    char_valid = 1'b0;
    char_data  = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_we",    32'(vram_we), 32'd0);
    check("rst_addr",  {20'd0, vram_waddr}, 32'd0);
    check("rst_data",  {24'd0, vram_wdata}, 32'd0);
    check("rst_busy",  32'(busy), 32'd1);
    check("rst_ready", 32'(char_ready), 32'd0);
    check("rst_cur",   cur(cursor_row, cursor_col), cur(5'd0, 7'd0));

    rst = 1'b0;
    clear_all_check("pwr_clr");
    check("pwr_ready", 32'(char_ready), 32'd1);

    // back-to-back printables
    send(8'h41);
    check("a_wr",  wr(vram_we, vram_waddr, vram_wdata), wr(1'b1, 12'd0, 8'h41));
    send(8'h42);
    check("b_wr",  wr(vram_we, vram_waddr, vram_wdata), wr(1'b1, 12'd1, 8'h42));
    check("b_cur", cur(cursor_row, cursor_col), cur(5'd0, 7'd2));
    @(negedge clk);
    check("b_we_drop", 32'(vram_we), 32'd0);

    // two LFs to reach row 2, then five glyphs to (2,5)
    for (int r = 1; r <= 2; r++) begin
      send(8'h0A);
      check("lf_nowr", 32'(vram_we), 32'd0);
      check("lf_cur", cur(cursor_row, cursor_col), cur(5'(r), 7'd0));
      clear_line_check("lf_clr", r * 80);
    end
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
    check("p_last_wr", wr(vram_we, vram_waddr, vram_wdata), wr(1'b1, 12'd164, 8'h65));
    check("p_cur", cur(cursor_row, cursor_col), cur(5'd2, 7'd5));

    send(8'h0A);
    check("lf25_nowr",  32'(vram_we), 32'd0);
    check("lf25_ready", 32'(char_ready), 32'd0);
    check("lf25_cur",   cur(cursor_row, cursor_col), cur(5'd3, 7'd0));
    clear_line_check("lf25_clr", 240);
    check("lf25_cur_end", cur(cursor_row, cursor_col), cur(5'd3, 7'd0));

    // walk to row 29, fill 79 columns, then the wrapping glyph
    for (int r = 4; r <= 29; r++) begin
      send(8'h0A);
      check("walk_cur", cur(cursor_row, cursor_col), cur(5'(r), 7'd0));
      clear_line_check("walk_clr", r * 80);
    end
    for (int i = 0; i < 79; i++) send(8'h30);
    check("fill_cur", cur(cursor_row, cursor_col), cur(5'd29, 7'd79));
    check("fill_ready", 32'(char_ready), 32'd1);
    send(8'h5A);
    check("wrap_wr",  wr(vram_we, vram_waddr, vram_wdata), wr(1'b1, 12'd2399, 8'h5A));
    check("wrap_cur", cur(cursor_row, cursor_col), cur(5'd0, 7'd0));
    check("wrap_ready", 32'(char_ready), 32'd0);
    clear_line_check("wrap_clr", 0);

    // backspace at column 0 is a no-op
    send(8'h08);
    check("bs0_we",  32'(vram_we), 32'd0);
    check("bs0_cur", cur(cursor_row, cursor_col), cur(5'd0, 7'd0));
    check("bs0_ready", 32'(char_ready), 32'd1);

    // backspace at (1,3), then CR
    send(8'h0A);
    clear_line_check("bs_lf_clr", 80);
    for (int i = 0; i < 3; i++) send(8'h58);
    check("bs_pre_cur", cur(cursor_row, cursor_col), cur(5'd1, 7'd3));
    send(8'h08);
    check("bs_wr",  wr(vram_we, vram_waddr, vram_wdata), wr(1'b1, 12'd82, 8'h20));
    check("bs_cur", cur(cursor_row, cursor_col), cur(5'd1, 7'd2));
    send(8'h0D);
    check("cr_we",  32'(vram_we), 32'd0);
    check("cr_cur", cur(cursor_row, cursor_col), cur(5'd1, 7'd0));

    // valid held while busy must not be taken: hold 0x51 across a line clear
    char_valid = 1'b1;
    char_data  = 8'h0A;
    @(negedge clk);
    char_data  = 8'h51;
    repeat (80) @(negedge clk);
    check("hold_last_clr", wr(vram_we, vram_waddr, vram_wdata), wr(1'b1, 12'd239, 8'h20));
    @(negedge clk);
    char_valid = 1'b0;
    check("hold_wr",  wr(vram_we, vram_waddr, vram_wdata), wr(1'b1, 12'd160, 8'h51));
    check("hold_cur", cur(cursor_row, cursor_col), cur(5'd2, 7'd1));

    // form feed
    send(8'h0C);
    check("ff_nowr", 32'(vram_we), 32'd0);
    check("ff_busy", 32'(busy), 32'd1);
    check("ff_cur",  cur(cursor_row, cursor_col), cur(5'd0, 7'd0));
    clear_all_check("ff_clr");

    // reset in the middle of a line clear
    send(8'h0A);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check("mid_wr", wr(vram_we, vram_waddr, vram_wdata), wr(1'b1, 12'(80 + k), 8'h20));
    end
    rst = 1'b1;
    #1;
    check("mid_rst_we",   32'(vram_we), 32'd0);
    check("mid_rst_cur",  cur(cursor_row, cursor_col), cur(5'd0, 7'd0));
    check("mid_rst_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    clear_all_check("rst_clr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
